// File: rtl/hls_call_sequencer_if.sv
// Host stream and accelerator handshake bundle for hls_call_sequencer.
// slave  : the sequencer's view.
// master : the environment's view (host stream source/sink plus the accelerator).
interface hls_call_sequencer_if #(
  parameter int ARG_W = 32,
  parameter int RET_W = 32,
  parameter int LAT_W = 16
);
  logic             arg_valid;
  logic             arg_ready;
  logic [ARG_W-1:0] arg_data;
  logic             res_valid;
  logic             res_ready;
  logic [RET_W-1:0] res_data;
  logic [LAT_W-1:0] res_latency;
  logic             acc_start;
  logic             acc_ready;
  logic             acc_finish;
  logic [ARG_W-1:0] acc_arg;
  logic [RET_W-1:0] acc_return_val;

  modport slave (
    input  arg_valid, arg_data, res_ready, acc_ready, acc_finish, acc_return_val,
    output arg_ready, res_valid, res_data, res_latency, acc_start, acc_arg
  );

  modport master (
    output arg_valid, arg_data, res_ready, acc_ready, acc_finish, acc_return_val,
    input  arg_ready, res_valid, res_data, res_latency, acc_start, acc_arg
  );
endinterface

// File: rtl/hls_call_sequencer.sv
// Drives an HLS accelerator (start/ready/finish, one constant argument) from a queue of
// argument words, one call per word, and queues {return value, call latency} results.
//
// state  | meaning
// IDLE   | no call outstanding; issue when an argument is queued and a result slot is free
// ISSUE  | acc_start high, argument latched, waiting for acc_ready
// WAIT   | call accepted, counting latency until acc_finish
module hls_call_sequencer #(
  parameter int ARG_W = 32,
  parameter int RET_W = 32,
  parameter int DEPTH = 4,
  parameter int LAT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  hls_call_sequencer_if.slave bus,
  output logic [31:0]         calls_done,
  output logic                busy,
  output logic                protocol_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = RET_W + LAT_W;
  localparam logic [LAT_W-1:0] LAT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  state_t state, state_nxt;

  logic [ARG_W-1:0] in_mem [DEPTH];
  logic [AW:0]      in_wr, in_rd;
  logic             in_empty, in_full, in_push, in_pop;

  logic [OW-1:0]    out_mem [DEPTH];
  logic [AW:0]      out_wr, out_rd;
  logic             out_empty, out_full, out_push, out_pop;
  logic [OW-1:0]    out_head;

  logic [ARG_W-1:0] acc_arg_q;
  logic [LAT_W-1:0] lat_cnt, lat_inc, lat_now;
  logic             accept, err_set;

  // input FIFO flags; pointers carry a wrap bit to tell full from empty
  assign in_empty      = (in_wr == in_rd);
  assign in_full       = (in_wr[AW] != in_rd[AW]) && (in_wr[AW-1:0] == in_rd[AW-1:0]);
  assign in_push       = bus.arg_valid && !in_full;
  assign bus.arg_ready = !in_full && !reset;

  assign out_empty     = (out_wr == out_rd);
  assign out_full      = (out_wr[AW] != out_rd[AW]) && (out_wr[AW-1:0] == out_rd[AW-1:0]);
  assign out_pop       = bus.res_ready && !out_empty;
  assign out_head      = out_mem[out_rd[AW-1:0]];

  // results are presented fall-through; zero when nothing is queued
  assign bus.res_valid   = !out_empty;
  assign bus.res_data    = out_empty ? '0 : out_head[OW-1 -: RET_W];
  assign bus.res_latency = out_empty ? '0 : out_head[LAT_W-1:0];

  assign bus.acc_start = (state == S_ISSUE);
  assign bus.acc_arg   = acc_arg_q;
  assign busy          = (state != S_IDLE) || !in_empty || !out_empty;

  assign lat_inc = (lat_cnt == LAT_MAX) ? lat_cnt : lat_cnt + 1'b1;

  // argument storage (no reset needed; pointers define validity)
  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr[AW-1:0]] <= bus.arg_data;
  end

  // result storage
  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wr[AW-1:0]] <= {bus.acc_return_val, lat_now};
  end

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      in_wr  <= '0;
      in_rd  <= '0;
      out_wr <= '0;
      out_rd <= '0;
    end else begin
      if (in_push)  in_wr  <= in_wr + 1'b1;
      if (in_pop)   in_rd  <= in_rd + 1'b1;
      if (out_push) out_wr <= out_wr + 1'b1;
      if (out_pop)  out_rd <= out_rd + 1'b1;
    end
  end

  // next state, FIFO pop/push and latency value for the current cycle
  always_comb begin
    state_nxt = state;
    in_pop    = 1'b0;
    out_push  = 1'b0;
    accept    = 1'b0;
    err_set   = 1'b0;
    lat_now   = lat_inc;
    unique case (state)
      S_IDLE: begin
        err_set = bus.acc_finish;
        // checking !out_full here reserves the slot: only this call can fill it
        if (!in_empty && !out_full) begin
          state_nxt = S_ISSUE;
          in_pop    = 1'b1;
        end
      end
      S_ISSUE: begin
        lat_now = LAT_W'(1);
        if (bus.acc_ready) begin
          accept = 1'b1;
          if (bus.acc_finish) begin
            out_push  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_WAIT;
          end
        end else begin
          err_set = bus.acc_finish;
        end
      end
      S_WAIT: begin
        if (bus.acc_finish) begin
          out_push  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // state, latched argument, latency counter and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      acc_arg_q    <= '0;
      lat_cnt      <= '0;
      calls_done   <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_pop)                     acc_arg_q    <= in_mem[in_rd[AW-1:0]];
      if (accept || state == S_WAIT)  lat_cnt      <= lat_now;
      if (out_push)                   calls_done   <= calls_done + 32'd1;
      if (err_set)                    protocol_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hls_call_sequencer.sv
// Bench for hls_call_sequencer: two instances (LAT_W=16 and LAT_W=4) share one stimulus;
// a transaction-level model checks every cycle, a vector table and directed sequences
// cover the multi-cycle corners, then a randomized run.
module tb_hls_call_sequencer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        arg_valid, res_ready, acc_ready, acc_finish;
  logic [31:0] arg_data, acc_ret;
  logic [31:0] calls_done, calls_done4;
  logic        busy, busy4, perr, perr4;

  always #5 clk = ~clk;

  hls_call_sequencer_if #(.ARG_W(32), .RET_W(32), .LAT_W(16)) b16 ();
  hls_call_sequencer_if #(.ARG_W(32), .RET_W(32), .LAT_W(4))  b4 ();

  assign b16.arg_valid = arg_valid;  assign b4.arg_valid = arg_valid;
  assign b16.arg_data = arg_data;    assign b4.arg_data = arg_data;
  assign b16.res_ready = res_ready;  assign b4.res_ready = res_ready;
  assign b16.acc_ready = acc_ready;  assign b4.acc_ready = acc_ready;
  assign b16.acc_finish = acc_finish; assign b4.acc_finish = acc_finish;
  assign b16.acc_return_val = acc_ret; assign b4.acc_return_val = acc_ret;

  hls_call_sequencer #(.ARG_W(32), .RET_W(32), .DEPTH(DEPTH), .LAT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(b16),
    .calls_done(calls_done), .busy(busy), .protocol_err(perr));

  hls_call_sequencer #(.ARG_W(32), .RET_W(32), .DEPTH(DEPTH), .LAT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(b4),
    .calls_done(calls_done4), .busy(busy4), .protocol_err(perr4));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- accelerator behaviour ----------------
  bit          mode_rand = 0;
  bit          spur_req  = 0;
  int          cfg_rd = 0, cfg_fd = 0;
  logic [31:0] cfg_ret = '0;
  int          ph = 0, cnt = 0, fd = 0;
  logic [31:0] ret_pend = '0;

  task automatic acc_accept();
    acc_ready = 1'b1;
    if (fd == 0) begin
      acc_finish = 1'b1;
      acc_ret    = ret_pend;
      ph         = 0;
    end else begin
      cnt = fd;
      ph  = 2;
    end
  endtask

  initial begin
    int rd;
    acc_ready = 1'b0; acc_finish = 1'b0; acc_ret = '0;
    forever begin
      @(posedge clk); #2;
      acc_ready  = 1'b0;
      acc_finish = 1'b0;
      if (reset) begin
        ph = 0; spur_req = 0;
      end else begin
        case (ph)
          0: if (b16.acc_start) begin
            if (mode_rand) begin
              rd = $urandom_range(0, 3);
              fd = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 22) : $urandom_range(0, 5);
              ret_pend = $urandom;
            end else begin
              rd = cfg_rd; fd = cfg_fd; ret_pend = cfg_ret;
            end
            if (rd == 0) acc_accept();
            else begin cnt = rd; ph = 1; end
          end
          1: begin cnt--; if (cnt == 0) acc_accept(); end
          2: begin
            cnt--;
            if (cnt == 0) begin acc_finish = 1'b1; acc_ret = ret_pend; ph = 0; end
          end
          default: ph = 0;
        endcase
        if (spur_req && !acc_finish && !acc_ready && ph != 2) begin
          acc_finish = 1'b1;
          spur_req   = 0;
        end
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef struct { logic [31:0] ret; int lat; } res_t;
  logic [31:0] args_q [$];
  res_t        res_q [$];
  logic [31:0] cur_arg;
  bit          have_arg, waiting, err_exp, prev_idle, prev_cond, prev_start;
  int          acc_cyc, done_cnt, n_starts, n_pushed, start_len, last_start_len;
  int          start_cyc_last, start_cyc_prev, cyc = 0;

  task automatic model_clear();
    args_q.delete(); res_q.delete();
    have_arg = 0; waiting = 0; err_exp = 0; prev_idle = 1; prev_cond = 0; prev_start = 0;
    done_cnt = 0; n_starts = 0; n_pushed = 0; start_len = 0; last_start_len = 0;
    start_cyc_last = 0; start_cyc_prev = 0;
  endtask

  task automatic monitor_cycle();
    bit   start, new_call, idle_now, accept;
    res_t r;
    start    = b16.acc_start;
    new_call = start && !prev_start;
    // a call must start exactly when the previous cycle was idle with work and room
    if (prev_idle) chk("issue_timing", start, prev_cond);
    if (new_call) begin
      n_starts++;
      start_cyc_prev = start_cyc_last;
      start_cyc_last = cyc;
      start_len = 1;
      if (args_q.size() != 0) cur_arg = args_q.pop_front();
      else cur_arg = 'x;
      have_arg = 1;
    end else if (start) begin
      start_len++;
    end
    if (have_arg) chk("acc_arg", b16.acc_arg, cur_arg);
    else          chk("acc_arg_reset", b16.acc_arg, 0);
    chk("arg_ready", b16.arg_ready, args_q.size() < DEPTH);
    chk("res_valid", b16.res_valid, res_q.size() != 0);
    chk("res_valid4", b4.res_valid, res_q.size() != 0);
    if (res_q.size() != 0) begin
      chk("res_data", b16.res_data, res_q[0].ret);
      chk("res_lat16", b16.res_latency, (res_q[0].lat > 65535) ? 65535 : res_q[0].lat);
      chk("res_data4", b4.res_data, res_q[0].ret);
      chk("res_lat4", b4.res_latency, (res_q[0].lat > 15) ? 15 : res_q[0].lat);
    end else begin
      chk("res_data_empty", b16.res_data, 0);
    end
    chk("calls_done", calls_done, done_cnt);
    chk("calls_done4", calls_done4, done_cnt);
    chk("protocol_err", perr, err_exp);
    chk("protocol_err4", perr4, err_exp);
    idle_now = !start && !waiting;
    chk("busy", busy, !idle_now || args_q.size() != 0 || res_q.size() != 0);
    prev_cond = idle_now && args_q.size() != 0 && res_q.size() < DEPTH;
    prev_idle = idle_now;
    if (res_q.size() != 0 && res_ready) res_q.delete(0);
    accept = start && acc_ready;
    if (accept) last_start_len = start_len;
    if (acc_finish) begin
      if (waiting || accept) begin
        r.ret = acc_ret;
        r.lat = waiting ? (cyc - acc_cyc + 1) : 1;
        res_q.push_back(r);
        done_cnt++;
        waiting = 0;
      end else begin
        err_exp = 1;
      end
    end else if (accept) begin
      waiting = 1;
      acc_cyc = cyc;
    end
    if (arg_valid && b16.arg_ready) begin
      args_q.push_back(arg_data);
      n_pushed++;
    end
    prev_start = start;
  endtask

  initial begin
    model_clear();
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) model_clear();
      else monitor_cycle();
    end
  end

  // ---------------- host-side helpers (called at posedge + 1) ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; arg_valid = 1'b0; res_ready = 1'b0;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic push_arg(input logic [31:0] d);
    int n = 0;
    arg_valid = 1'b1; arg_data = d;
    @(negedge clk);
    while (!b16.arg_ready && n < 100) begin @(negedge clk); n++; end
    chk("push_timeout", b16.arg_ready, 1);
    tick(1);
    arg_valid = 1'b0;
  endtask

  task automatic wait_res(input int budget);
    int n = 0;
    @(negedge clk);
    while (!b16.res_valid && n < budget) begin @(negedge clk); n++; end
    chk("wait_res_timeout", b16.res_valid, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin @(negedge clk); n++; end
    chk("wait_idle_timeout", busy, 0);
  endtask

  task automatic wait_calls(input int target, input int budget);
    int n = 0;
    @(negedge clk);
    while (calls_done != target && n < budget) begin @(negedge clk); n++; end
    chk("wait_calls_timeout", calls_done, target);
  endtask

  typedef struct {
    logic [31:0] arg; logic [31:0] ret; int rd; int fd; int lat16; int lat4; int slen;
  } vec_t;
  vec_t vecs [8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_0005, 32'h0000_000A, 0, 3,  4,  4, 1};
    vecs[1] = '{32'h0000_1234, 32'h0000_BEEF, 5, 2,  3,  3, 6};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 0, 0,  1,  1, 1};
    vecs[3] = '{32'hA5A5_0001, 32'h1111_2222, 2, 13, 14, 14, 3};
    vecs[4] = '{32'hA5A5_0002, 32'h3333_4444, 0, 14, 15, 15, 1};
    vecs[5] = '{32'hA5A5_0003, 32'h5555_6666, 1, 15, 16, 15, 2};
    vecs[6] = '{32'hA5A5_0004, 32'h7777_8888, 0, 19, 20, 15, 1};
    vecs[7] = '{32'hA5A5_0005, 32'h9999_AAAA, 3, 40, 41, 15, 4};

    reset = 1'b1; arg_valid = 1'b0; arg_data = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_calls_done", calls_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", b16.res_valid, 0);
    chk("rst_acc_start", b16.acc_start, 0);
    chk("rst_acc_arg", b16.acc_arg, 0);
    chk("rst_perr", perr, 0);
    chk("rst_arg_ready", b16.arg_ready, 1);
    tick(1);

    // single calls from the vector table
    for (int i = 0; i < 8; i++) begin
      cfg_rd = vecs[i].rd; cfg_fd = vecs[i].fd; cfg_ret = vecs[i].ret;
      push_arg(vecs[i].arg);
      wait_res(200);
      chk("vec_ret", b16.res_data, vecs[i].ret);
      chk("vec_lat16", b16.res_latency, vecs[i].lat16);
      chk("vec_lat4", b4.res_latency, vecs[i].lat4);
      chk("vec_start_len", last_start_len, vecs[i].slen);
      chk("vec_calls_done", calls_done, i + 1);
      tick(1);
      res_ready = 1'b1;
      tick(1);
      res_ready = 1'b0;
      wait_idle(20);
      tick(1);
    end

    // output FIFO back-pressure limits the number of issued calls
    do_reset();
    cfg_rd = 0; cfg_fd = 1; cfg_ret = 32'h0000_00C0;
    for (int k = 0; k < 4; k++) push_arg(32'h100 + k);
    tick(30);
    @(negedge clk);
    chk("bp_calls", calls_done, 4);
    chk("bp_starts", n_starts, 4);
    chk("bp_arg_ready", b16.arg_ready, 1);
    tick(1);
    for (int k = 0; k < 4; k++) push_arg(32'h200 + k);
    tick(20);
    @(negedge clk);
    chk("bp_blocked_calls", calls_done, 4);
    chk("bp_in_full", b16.arg_ready, 0);
    tick(1);
    res_ready = 1'b1;
    tick(1);
    res_ready = 1'b0;
    tick(15);
    @(negedge clk);
    chk("bp_after_pop", calls_done, 5);
    chk("bp_after_pop_starts", n_starts, 5);
    tick(1);
    res_ready = 1'b1;
    wait_idle(200);
    chk("bp_total", calls_done, 8);
    tick(1);
    res_ready = 1'b0;

    // finish in the accept cycle: lat=1 and two-cycle start spacing
    do_reset();
    cfg_rd = 0; cfg_fd = 0; cfg_ret = 32'h0000_0042;
    push_arg(32'h0000_0011);
    push_arg(32'h0000_0012);
    wait_calls(2, 50);
    chk("b2b_spacing", start_cyc_last - start_cyc_prev, 2);
    chk("b2b_lat", b16.res_latency, 1);
    tick(1);
    res_ready = 1'b1;
    wait_idle(50);
    tick(1);
    res_ready = 1'b0;

    // spurious finish in IDLE, then reset in the middle of a call
    do_reset();
    spur_req = 1;
    tick(3);
    @(negedge clk);
    chk("spur_idle_perr", perr, 1);
    chk("spur_idle_no_result", b16.res_valid, 0);
    chk("spur_idle_calls", calls_done, 0);
    tick(5);
    @(negedge clk);
    chk("spur_idle_sticky", perr, 1);
    tick(1);
    cfg_rd = 0; cfg_fd = 30; cfg_ret = 32'h0000_0777;
    push_arg(32'h0000_0077);
    tick(6);
    @(negedge clk);
    chk("midcall_start_low", b16.acc_start, 0);
    chk("midcall_busy", busy, 1);
    tick(1);
    do_reset();
    @(negedge clk);
    chk("rst2_calls_done", calls_done, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_res_valid", b16.res_valid, 0);
    chk("rst2_res_data", b16.res_data, 0);
    chk("rst2_perr", perr, 0);
    chk("rst2_acc_start", b16.acc_start, 0);
    chk("rst2_acc_arg", b16.acc_arg, 0);
    chk("rst2_arg_ready", b16.arg_ready, 1);
    tick(40);
    @(negedge clk);
    chk("rst2_abandoned", b16.res_valid, 0);
    tick(1);

    // spurious finish in ISSUE before the accept
    cfg_rd = 6; cfg_fd = 3; cfg_ret = 32'h0000_0999;
    push_arg(32'h0000_0099);
    tick(1);
    spur_req = 1;
    wait_calls(1, 50);
    chk("spur_issue_perr", perr, 1);
    chk("spur_issue_ret", b16.res_data, 32'h0000_0999);
    chk("spur_issue_lat", b16.res_latency, 4);
    tick(1);
    res_ready = 1'b1;
    wait_idle(30);
    tick(1);

    // randomized traffic against the model
    do_reset();
    mode_rand = 1;
    for (int c = 0; c < 1500; c++) begin
      arg_valid = ($urandom_range(0, 1) == 1);
      arg_data  = $urandom;
      res_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    arg_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle(2000);
    chk("rand_all_served", calls_done, n_pushed);
    mode_rand = 0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
